// File: rtl/cnu_sched_if.sv
// Control/memory bundle between the decoder controller and the check-node row scheduler.
// master = controller side, slave = scheduler side.
interface cnu_sched_if #(
  parameter int ADDR_WID = 5,
  parameter int ITER_WID = 5
);
  logic                start;
  logic                abort;
  logic [ITER_WID-1:0] max_iter;
  logic                syn_ok;
  logic                rd_en;
  logic [ADDR_WID-1:0] rd_addr;
  logic                cnu_in;
  logic                iter_0;
  logic                wr_en;
  logic [ADDR_WID-1:0] wr_addr;
  logic                busy;
  logic                done;
  logic [ITER_WID-1:0] iter_cnt;
  logic                early_stop;

  modport master (
    output start, abort, max_iter, syn_ok,
    input  rd_en, rd_addr, cnu_in, iter_0, wr_en, wr_addr,
    input  busy, done, iter_cnt, early_stop
  );

  modport slave (
    input  start, abort, max_iter, syn_ok,
    output rd_en, rd_addr, cnu_in, iter_0, wr_en, wr_addr,
    output busy, done, iter_cnt, early_stop
  );
endinterface

// File: rtl/cnu_sched.sv
// Row scheduler for the 6-input min-sum check-node cell: issues row reads every
// third cycle, delays them into capture and write-back strobes, and counts iterations.
module cnu_sched #(
  parameter int ROW_NUM  = 18,
  parameter int ADDR_WID = 5,
  parameter int ITER_WID = 5
) (
  input logic        clk,
  input logic        reset,
  cnu_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, EVAL} state_t;

  localparam logic [ADDR_WID-1:0] LAST_ROW = ADDR_WID'(ROW_NUM - 1);
  localparam logic [ITER_WID-1:0] ITER_MAX = '1;

  function automatic logic [ITER_WID-1:0] sat_inc(input logic [ITER_WID-1:0] v);
    return (v == ITER_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [ITER_WID-1:0] clamp_limit(input logic [ITER_WID-1:0] v);
    return (v == '0) ? ITER_WID'(1) : v;
  endfunction

  state_t              state;
  logic [1:0]          gap;
  logic [ADDR_WID-1:0] row;
  logic [ITER_WID-1:0] limit;
  logic [ITER_WID-1:0] iter_cnt;
  logic [ITER_WID-1:0] iter_next;
  logic                rd_en;
  logic                iter_0;
  logic                busy;
  logic                done;
  logic                early_stop;

  logic                vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6;
  logic [ADDR_WID-1:0] addr_p1, addr_p2, addr_p3, addr_p4, addr_p5, addr_p6;

  assign iter_next = sat_inc(iter_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gap        <= '0;
      row        <= '0;
      limit      <= ITER_WID'(1);
      iter_cnt   <= '0;
      rd_en      <= 1'b0;
      iter_0     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      early_stop <= 1'b0;
    end else if (bus.abort) begin
      state    <= IDLE;
      gap      <= '0;
      row      <= '0;
      iter_cnt <= '0;
      rd_en    <= 1'b0;
      iter_0   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= RUN;
            limit      <= clamp_limit(bus.max_iter);
            iter_cnt   <= '0;
            early_stop <= 1'b0;
            iter_0     <= 1'b1;
            busy       <= 1'b1;
            gap        <= '0;
            row        <= '0;
            rd_en      <= 1'b1;
          end
        end
        RUN: begin
          // The cell reuses its Lq registers at issue+1 and issue+3, so rows stay 3 cycles apart.
          if (gap == 2'd2) begin
            gap   <= '0;
            rd_en <= 1'b1;
            row   <= row + 1'b1;
          end else if (gap == 2'd0 && row == LAST_ROW) begin
            rd_en <= 1'b0;
            state <= WAIT;
          end else begin
            gap   <= gap + 1'b1;
            rd_en <= 1'b0;
          end
        end
        WAIT: begin
          if (vld_p6 && addr_p6 == LAST_ROW)
            state <= EVAL;
        end
        EVAL: begin
          iter_cnt <= iter_next;
          iter_0   <= 1'b0;
          if (bus.syn_ok || iter_next == limit) begin
            state      <= IDLE;
            done       <= 1'b1;
            busy       <= 1'b0;
            early_stop <= bus.syn_ok;
          end else begin
            state <= RUN;
            gap   <= '0;
            row   <= '0;
            rd_en <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0; vld_p2  <= 1'b0; vld_p3  <= 1'b0;
      vld_p4  <= 1'b0; vld_p5  <= 1'b0; vld_p6  <= 1'b0;
      addr_p1 <= '0;   addr_p2 <= '0;   addr_p3 <= '0;
      addr_p4 <= '0;   addr_p5 <= '0;   addr_p6 <= '0;
    end else if (bus.abort) begin
      vld_p1  <= 1'b0; vld_p2  <= 1'b0; vld_p3  <= 1'b0;
      vld_p4  <= 1'b0; vld_p5  <= 1'b0; vld_p6  <= 1'b0;
      addr_p1 <= '0;   addr_p2 <= '0;   addr_p3 <= '0;
      addr_p4 <= '0;   addr_p5 <= '0;   addr_p6 <= '0;
    end else begin
      // stage 1: cell capture
      vld_p1  <= rd_en;   addr_p1 <= row;
      vld_p2  <= vld_p1;  addr_p2 <= addr_p1;
      vld_p3  <= vld_p2;  addr_p3 <= addr_p2;
      vld_p4  <= vld_p3;  addr_p4 <= addr_p3;
      vld_p5  <= vld_p4;  addr_p5 <= addr_p4;
      // stage 6: cell output valid, row write-back
      vld_p6  <= vld_p5;  addr_p6 <= addr_p5;
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = row;
  assign bus.cnu_in     = vld_p1;
  assign bus.wr_en      = vld_p6;
  assign bus.wr_addr    = addr_p6;
  assign bus.iter_0     = iter_0;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.iter_cnt   = iter_cnt;
  assign bus.early_stop = early_stop;

endmodule

// File: tb/tb_cnu_sched.sv
// Bench for cnu_sched (ROW_NUM=4): scenario table, reset sequence and random traffic,
// all checked cycle by cycle against a timeline model of the schedule.
module tb_cnu_sched;
  localparam int R  = 4;
  localparam int AW = 5;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset;

  cnu_sched_if #(.ADDR_WID(AW), .ITER_WID(IW)) bus ();

  cnu_sched #(.ROW_NUM(R), .ADDR_WID(AW), .ITER_WID(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  // Model: iteration start cycle m_s; row k reads at m_s+3k, writes back at m_s+3k+6.
  bit m_act, m_i0, m_done, m_es;
  int m_s, m_it, m_mx;

  typedef struct {
    int mx;
    int xs1, xs2;
    int ab;
    int sy1, sy2;
    int done_at;
    int cnt;
    int es;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, n, act, exp);
    end
  endtask

  task automatic model_clear();
    m_act = 0; m_i0 = 0; m_done = 0; m_es = 0;
    m_s = 0; m_it = 0; m_mx = 1;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit sy, input int mxi);
    int t;
    t = n - m_s;
    m_done = 0;
    if (reset) begin
      model_clear();
    end else if (ab) begin
      m_act = 0; m_it = 0; m_i0 = 0;
    end else if (m_act) begin
      if (t == 3*R + 4) begin
        m_it = (m_it < (1 << IW) - 1) ? m_it + 1 : m_it;
        m_i0 = 0;
        if (sy || m_it == m_mx) begin
          m_act = 0; m_done = 1; m_es = sy;
        end else begin
          m_s = n + 1;
        end
      end
    end else if (st) begin
      m_act = 1; m_s = n + 1; m_it = 0; m_es = 0; m_i0 = 1;
      m_mx = (mxi == 0) ? 1 : mxi;
    end
    n++;
  endtask

  task automatic check_cycle();
    int t;
    bit e_rd, e_cnu, e_wr;
    t = n - m_s;
    e_rd  = m_act && t >= 0 && t < 3*R && (t % 3) == 0;
    e_cnu = m_act && t >= 1 && t <= 3*R - 2 && ((t - 1) % 3) == 0;
    e_wr  = m_act && t >= 6 && t <= 3*R + 3 && ((t - 6) % 3) == 0;
    chk("ctrl{rd,cnu,wr,busy,done,iter0,es}",
        {25'd0, bus.rd_en, bus.cnu_in, bus.wr_en, bus.busy, bus.done, bus.iter_0, bus.early_stop},
        {25'd0, e_rd, e_cnu, e_wr, m_act, m_done, m_i0, m_es});
    chk("iter_cnt", 32'(bus.iter_cnt), 32'(m_it));
    if (e_rd) chk("rd_addr", 32'(bus.rd_addr), 32'(t / 3));
    if (e_wr) chk("wr_addr", 32'(bus.wr_addr), 32'((t - 6) / 3));
  endtask

  task automatic tick(input bit st, input bit ab, input bit sy, input logic [IW-1:0] mxi);
    bus.start = st; bus.abort = ab; bus.syn_ok = sy; bus.max_iter = mxi;
    @(posedge clk);
    model_edge(st, ab, sy, int'(mxi));
    #1;
    check_cycle();
  endtask

  initial begin
    int done_at, cnt, es, first_rd;

    vecs[0] = '{mx:1,  xs1:-1, xs2:-1, ab:-1, sy1:-1, sy2:-1, done_at:18, cnt:1, es:0};
    vecs[1] = '{mx:3,  xs1:-1, xs2:-1, ab:-1, sy1:-1, sy2:-1, done_at:52, cnt:3, es:0};
    vecs[2] = '{mx:10, xs1:-1, xs2:-1, ab:-1, sy1:10, sy2:34, done_at:35, cnt:2, es:1};
    vecs[3] = '{mx:1,  xs1:-1, xs2:-1, ab:9,  sy1:-1, sy2:-1, done_at:-1, cnt:0, es:0};
    vecs[4] = '{mx:1,  xs1:5,  xs2:17, ab:-1, sy1:-1, sy2:-1, done_at:18, cnt:1, es:0};
    vecs[5] = '{mx:0,  xs1:-1, xs2:-1, ab:-1, sy1:-1, sy2:-1, done_at:18, cnt:1, es:0};

    bus.start = 0; bus.abort = 0; bus.syn_ok = 0; bus.max_iter = '0;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    chk("reset_addr", {22'd0, bus.rd_addr, bus.wr_addr}, 32'd0);
    reset = 1'b0;
    tick(0, 0, 0, '0);
    tick(0, 0, 0, '0);

    foreach (vecs[i]) begin
      done_at = -1;
      for (int lc = 0; lc < 64; lc++) begin
        tick(lc == 0 || lc == vecs[i].xs1 || lc == vecs[i].xs2,
             lc == vecs[i].ab,
             lc == vecs[i].sy1 || lc == vecs[i].sy2,
             IW'(vecs[i].mx));
        if (bus.done === 1'b1 && done_at < 0) begin
          done_at = lc + 1;
          cnt = int'(bus.iter_cnt);
          es = int'(bus.early_stop);
        end
      end
      if (done_at < 0) begin
        cnt = int'(bus.iter_cnt);
        es = int'(bus.early_stop);
      end
      chk($sformatf("vec%0d_done_cycle", i), 32'(done_at), 32'(vecs[i].done_at));
      chk($sformatf("vec%0d_iter_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_early_stop", i), 32'(es), 32'(vecs[i].es));
    end

    // Asynchronous reset mid-iteration, then a fresh start.
    for (int lc = 0; lc < 12; lc++) tick(lc == 0, 0, 0, IW'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {10'd0, bus.rd_en, bus.cnu_in, bus.wr_en, bus.busy, bus.done, bus.iter_0, bus.early_stop,
         bus.iter_cnt, bus.rd_addr, bus.wr_addr}, 32'd0);
    model_clear();
    first_rd = -1;
    for (int lc = 12; lc < 30; lc++) begin
      if (lc == 14) reset = 1'b0;
      tick(lc == 20, 0, 0, IW'(1));
      if (bus.rd_en === 1'b1 && first_rd < 0) first_rd = lc + 1;
    end
    chk("first_rd_after_reset", 32'(first_rd), 32'd21);

    for (int k = 0; k < 1500; k++) begin
      tick(($urandom % 8) == 0, ($urandom % 97) == 0, ($urandom % 4) == 0, IW'($urandom % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
